// File: rtl/fft_r22sdf_bf.sv
// Radix-2^2 single-path delay-feedback stage: BF2I (L1 feedback line) then BF2II (L2 line, -j rotation).
// Latency: L1 + L2 + 2 clocks from x to z; cnt_o tracks the block index of the sample on z.
// Backpressure: none; one sample per clock, blocks stream back-to-back with no stall.
//
// Ports:
//   clk_i, rst_n        - clock (rising edge) and asynchronous active-low reset
//   cnt_i / cnt_o       - sample index at the stage input / block index of the sample on z
//   x_re_i, x_im_i      - signed complex input sample
//   z_re_o, z_im_o      - signed complex output sample (registered)
module fft_r22sdf_bf #(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = 1024,
  parameter int FFT_NLOG2  = 10,
  parameter int STAGE      = 0,
  parameter int STAGES     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic [FFT_NLOG2-1:0]         cnt_i,
  output logic [FFT_NLOG2-1:0]         cnt_o,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o
);

  // Clamp so that an out-of-range STAGE still elaborates as the last stage.
  localparam int STG = (STAGE < STAGES) ? STAGE : STAGES - 1;
  localparam int L1  = FFT_N >> (2 * STG + 1);
  localparam int L2  = FFT_N >> (2 * STG + 2);
  localparam int PI  = FFT_NLOG2 - 1 - 2 * STG;
  localparam int PII = PI - 1;
  localparam int D   = L1 + L2 + 2;

  // Feedback delay lines: not reset, their contents are flushed by the first full block.
  logic signed [DATA_WIDTH-1:0] r_dl1_re [L1];
  logic signed [DATA_WIDTH-1:0] r_dl1_im [L1];
  logic signed [DATA_WIDTH-1:0] r_dl2_re [L2];
  logic signed [DATA_WIDTH-1:0] r_dl2_im [L2];

  logic signed [DATA_WIDTH-1:0] r_s1_re, r_s1_im;
  logic signed [DATA_WIDTH-1:0] r_z_re, r_z_im;
  logic [FFT_NLOG2-1:0]         r_cnt_o;

  // ---------------- BF2I ----------------
  logic                         w_ctl1;
  logic signed [DATA_WIDTH-1:0] w_h1_re, w_h1_im;
  logic signed [DATA_WIDTH-1:0] w_o1_re, w_o1_im;
  logic signed [DATA_WIDTH-1:0] w_p1_re, w_p1_im;

  assign w_ctl1  = cnt_i[PI];
  assign w_h1_re = r_dl1_re[L1-1];
  assign w_h1_im = r_dl1_im[L1-1];

  // First half of each 2*L1 span fills the line and drains the previous differences;
  // second half emits sums and stores differences.
  always_comb begin
    w_o1_re = w_h1_re;
    w_o1_im = w_h1_im;
    w_p1_re = x_re_i;
    w_p1_im = x_im_i;
    if (w_ctl1) begin
      w_o1_re = w_h1_re + x_re_i;
      w_o1_im = w_h1_im + x_im_i;
      w_p1_re = w_h1_re - x_re_i;
      w_p1_im = w_h1_im - x_im_i;
    end
  end

  // ---------------- BF2II ----------------
  // {c2[pI], c2[pII]} of the counter realigned to the BF2I output register.
  logic [1:0]                   w_c2;
  logic                         w_rot;
  logic signed [DATA_WIDTH-1:0] w_y_re, w_y_im;
  logic signed [DATA_WIDTH-1:0] w_h2_re, w_h2_im;
  logic signed [DATA_WIDTH-1:0] w_o2_re, w_o2_im;
  logic signed [DATA_WIDTH-1:0] w_p2_re, w_p2_im;

  assign w_c2    = 2'((cnt_i - FFT_NLOG2'(L1 + 1)) >> PII);
  assign w_rot   = w_c2[1] & w_c2[0];
  assign w_h2_re = r_dl2_re[L2-1];
  assign w_h2_im = r_dl2_im[L2-1];

  always_comb begin
    // Multiply by -j: (re, im) -> (im, -re)
    w_y_re = r_s1_re;
    w_y_im = r_s1_im;
    if (w_rot) begin
      w_y_re = r_s1_im;
      w_y_im = -r_s1_re;
    end
    w_o2_re = w_h2_re;
    w_o2_im = w_h2_im;
    w_p2_re = w_y_re;
    w_p2_im = w_y_im;
    if (w_c2[0]) begin
      w_o2_re = w_h2_re + w_y_re;
      w_o2_im = w_h2_im + w_y_im;
      w_p2_re = w_h2_re - w_y_re;
      w_p2_im = w_h2_im - w_y_im;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_re <= '0;
      r_s1_im <= '0;
      r_z_re  <= '0;
      r_z_im  <= '0;
      r_cnt_o <= '0;
    end else begin
      r_s1_re <= w_o1_re;
      r_s1_im <= w_o1_im;
      r_z_re  <= w_o2_re;
      r_z_im  <= w_o2_im;
      // Loaded one clock early so the register reads cnt_i - D while z is valid.
      r_cnt_o <= cnt_i - FFT_NLOG2'(D - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = L1 - 1; k > 0; k--) begin
      r_dl1_re[k] <= r_dl1_re[k-1];
      r_dl1_im[k] <= r_dl1_im[k-1];
    end
    r_dl1_re[0] <= w_p1_re;
    r_dl1_im[0] <= w_p1_im;
    for (int k = L2 - 1; k > 0; k--) begin
      r_dl2_re[k] <= r_dl2_re[k-1];
      r_dl2_im[k] <= r_dl2_im[k-1];
    end
    r_dl2_re[0] <= w_p2_re;
    r_dl2_im[0] <= w_p2_im;
  end

  assign z_re_o = r_z_re;
  assign z_im_o = r_z_im;
  assign cnt_o  = r_cnt_o;

endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// Bench for fft_r22sdf_bf: 4-point (16-bit and 8-bit) single stages and a chained 16-point pair.
// Expected outputs come from a 4-point DFT model (bins in 0,2,1,3 order) queued per DUT.
// Monitor pops each queue when the due cycle arrives and compares z and cnt_o.
module tb_fft_r22sdf_bf;

  localparam int D4  = 2 + 1 + 2;                 // N=4 stage 0
  localparam int D16 = (8 + 4 + 2) + (2 + 1 + 2); // N=16 stages 0 then 1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] cnt16;
  logic [1:0] cnt4;
  assign cnt4 = cnt16[1:0];

  logic signed [15:0] xa_re, xa_im, za_re, za_im;
  logic [1:0]         ca_o;
  logic signed [7:0]  xb_re, xb_im, zb_re, zb_im;
  logic [1:0]         cb_o;
  logic signed [15:0] xc_re, xc_im, m_re, m_im, zc_re, zc_im;
  logic [3:0]         cm, cc_o;

  fft_r22sdf_bf #(.DATA_WIDTH(16), .FFT_N(4), .FFT_NLOG2(2), .STAGE(0), .STAGES(1)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(cnt4), .cnt_o(ca_o),
    .x_re_i(xa_re), .x_im_i(xa_im), .z_re_o(za_re), .z_im_o(za_im));

  fft_r22sdf_bf #(.DATA_WIDTH(8), .FFT_N(4), .FFT_NLOG2(2), .STAGE(0), .STAGES(1)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(cnt4), .cnt_o(cb_o),
    .x_re_i(xb_re), .x_im_i(xb_im), .z_re_o(zb_re), .z_im_o(zb_im));

  fft_r22sdf_bf #(.DATA_WIDTH(16), .FFT_N(16), .FFT_NLOG2(4), .STAGE(0), .STAGES(2)) dut_c0 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(cnt16), .cnt_o(cm),
    .x_re_i(xc_re), .x_im_i(xc_im), .z_re_o(m_re), .z_im_o(m_im));

  fft_r22sdf_bf #(.DATA_WIDTH(16), .FFT_N(16), .FFT_NLOG2(4), .STAGE(1), .STAGES(2)) dut_c1 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(cm), .cnt_o(cc_o),
    .x_re_i(m_re), .x_im_i(m_im), .z_re_o(zc_re), .z_im_o(zc_im));

  typedef struct {
    int due;
    int re;
    int im;
    int cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t e;

  int cyc = 0;
  int cnt_next = 0;
  int n_tests = 0;
  int n_fail = 0;
  int vr[4];
  int vi[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrap(input int v, input int dw);
    int m;
    int r;
    m = 1 << dw;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  // X[k] = sum x[n] * (-j)^(n*k), emitted in bit-reversed bin order.
  function automatic void dft4(input int xr[4], input int xi[4], input int dw,
                               output int yr[4], output int yi[4]);
    for (int m = 0; m < 4; m++) begin
      int k;
      int sr;
      int si;
      k = ((m & 1) << 1) | (m >> 1);
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin sr += xr[n]; si += xi[n]; end
          1: begin sr += xi[n]; si -= xr[n]; end
          2: begin sr -= xr[n]; si -= xi[n]; end
          default: begin sr -= xi[n]; si += xr[n]; end
        endcase
      end
      yr[m] = wrap(sr, dw);
      yi[m] = wrap(si, dw);
    end
  endfunction

  function automatic void check(input string nm, input exp_t ex, input int cy,
                                input int gr, input int gi, input int gc);
    n_tests++;
    if (ex.due != cy || gr != ex.re || gi != ex.im || gc != ex.cnt) begin
      n_fail++;
      $display("FAIL %s cyc %0d (due %0d): got z=(%0d,%0d) cnt_o=%0d, expected z=(%0d,%0d) cnt_o=%0d",
               nm, cy, ex.due, gr, gi, gc, ex.re, ex.im, ex.cnt);
    end
  endfunction

  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      check("n4_w16", e, cyc, int'(za_re), int'(za_im), int'(ca_o));
    end
    if (qb.size() > 0 && qb[0].due <= cyc) begin
      e = qb.pop_front();
      check("n4_w8", e, cyc, int'(zb_re), int'(zb_im), int'(cb_o));
    end
    if (qc.size() > 0 && qc[0].due <= cyc) begin
      e = qc.pop_front();
      check("n16_chain", e, cyc, int'(zc_re), int'(zc_im), int'(cc_o));
    end
  end

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int cr, input int ci);
    @(posedge clk);
    #1;
    cnt16 = 4'(cnt_next);
    cnt_next++;
    xa_re = 16'(ar);
    xa_im = 16'(ai);
    xb_re = 8'(br);
    xb_im = 8'(bi);
    xc_re = 16'(cr);
    xc_im = 16'(ci);
  endtask

  task automatic align(input int m);
    while (cnt_next % m != 0) drive(0, 0, 0, 0, 0, 0);
  endtask

  // One 4-sample block into dut_a (on_b=0) or dut_b (on_b=1); caller keeps cnt aligned to 4.
  task automatic feed4(input bit on_b, input int xr[4], input int xi[4]);
    int yr[4];
    int yi[4];
    exp_t ex;
    dft4(xr, xi, on_b ? 8 : 16, yr, yi);
    for (int m = 0; m < 4; m++) begin
      ex.due = cyc + 1 + m + D4;
      ex.re  = yr[m];
      ex.im  = yi[m];
      ex.cnt = m;
      if (on_b) qb.push_back(ex);
      else qa.push_back(ex);
    end
    for (int n = 0; n < 4; n++) begin
      if (on_b) drive(0, 0, xr[n], xi[n], 0, 0);
      else drive(xr[n], xi[n], 0, 0, 0, 0);
    end
  endtask

  // Impulse into the chained 16-point pair: every output bin is 1.
  task automatic feed_c_impulse();
    exp_t ex;
    for (int m = 0; m < 16; m++) begin
      ex.due = cyc + 1 + m + D16;
      ex.re  = 1;
      ex.im  = 0;
      ex.cnt = m;
      qc.push_back(ex);
    end
    for (int n = 0; n < 16; n++) drive(0, 0, 0, 0, (n == 0) ? 1 : 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && k < 200) begin
      drive(0, 0, 0, 0, 0, 0);
      k++;
    end
    n_tests++;
    if ((qa.size() + qb.size() + qc.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs still pending, required 0",
               qa.size() + qb.size() + qc.size());
    end
  endtask

  task automatic check_zero(input string nm);
    n_tests++;
    if (za_re != 0 || za_im != 0 || ca_o != 0 || zb_re != 0 || zb_im != 0 || cb_o != 0 ||
        zc_re != 0 || zc_im != 0 || cc_o != 0 || m_re != 0 || m_im != 0 || cm != 0) begin
      n_fail++;
      $display("FAIL %s: got za=(%0d,%0d) ca=%0d zb=(%0d,%0d) cb=%0d zc=(%0d,%0d) cc=%0d cm=%0d, required all 0",
               nm, za_re, za_im, ca_o, zb_re, zb_im, cb_o, zc_re, zc_im, cc_o, cm);
    end
  endtask

  task automatic rand_block(input int dw);
    for (int n = 0; n < 4; n++) begin
      vr[n] = int'($urandom_range(0, (1 << dw) - 1)) - (1 << (dw - 1));
      vi[n] = int'($urandom_range(0, (1 << dw) - 1)) - (1 << (dw - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cnt16 = '0;
    xa_re = '0; xa_im = '0;
    xb_re = '0; xb_im = '0;
    xc_re = '0; xc_im = '0;
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    check_zero("reset_state");
    rst_n = 1'b1;
    align(16);

    // Directed 4-point blocks, back to back.
    vr = '{1, 0, 0, 0}; vi = '{0, 0, 0, 0};
    feed4(1'b0, vr, vi);
    vr = '{1, 1, 1, 1};
    feed4(1'b0, vr, vi);
    vr = '{0, 1, 0, 0};
    feed4(1'b0, vr, vi);
    // Random full-range blocks exercise wrap-around and the -j path.
    for (int b = 0; b < 6; b++) begin
      rand_block(16);
      feed4(1'b0, vr, vi);
    end

    // 8-bit overflow: 4*127 = 508 wraps to -4.
    vr = '{127, 127, 127, 127}; vi = '{0, 0, 0, 0};
    feed4(1'b1, vr, vi);
    for (int b = 0; b < 3; b++) begin
      rand_block(8);
      feed4(1'b1, vr, vi);
    end

    align(16);
    feed_c_impulse();
    drain();

    // Reset in the middle of a block: outputs clear at once and stay cleared.
    align(4);
    drive(int'($urandom_range(0, 999)), 5, 3, 3, 7, 7);
    drive(int'($urandom_range(0, 999)), -5, 3, 3, 7, 7);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async_clear");
    repeat (3) drive(11, 11, 11, 11, 11, 11);
    check_zero("reset_hold");
    rst_n = 1'b1;

    align(16);
    rand_block(16);
    feed4(1'b0, vr, vi);
    rand_block(8);
    feed4(1'b1, vr, vi);
    align(16);
    feed_c_impulse();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_bf.md
FFT_R22SDF_BF -- requirements
Module: fft_r22sdf_bf

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 25, real/imag sample width at input and output.
- FFT_N, 1024, FFT length, a power of 4.
- FFT_NLOG2, 10, log2(FFT_N).
- STAGE, 0, 0-based index of this radix-2^2 stage.
- STAGES, 5, total stage count, log4(FFT_N).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, sole clock; all logic on rising edge.
- rst_n, in, 1, reset.
- cnt_i, in, FFT_NLOG2, sample index of x at this stage input; increments by 1 per clock, wraps.
- cnt_o, out, FFT_NLOG2, block index of the sample currently on z.
- x_re_i, x_im_i, in, DATA_WIDTH each, signed complex input.
- z_re_o, z_im_o, out, DATA_WIDTH each, signed complex output.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Definitions: L1 = FFT_N >> (2*STAGE+1); L2 = FFT_N >> (2*STAGE+2); bit positions pI = FFT_NLOG2-1-2*STAGE, pII = pI-1.
REQ-005 Structure: BF2I (L1-deep feedback delay line) followed by BF2II (L2-deep feedback delay line); each stage output is registered.
REQ-006 BF2I control bit: cnt_i[pI].
- 0: push x into delay line; present delay-line head as output.
- 1: output head + x; push head - x.
REQ-007 BF2I output register SHALL hold the BF2I result one clock later.
REQ-008 BF2II aligned counter: c2 = cnt_i - L1 - 1 (mod 2^FFT_NLOG2).
REQ-009 BF2II input multiply by -j when c2[pI]=1 and c2[pII]=1: (re,im) -> (im, -re).
REQ-010 BF2II butterfly: same add/sub/pass rule as REQ-006, controlled by c2[pII].
REQ-011 BF2II output registered into z one clock later.
REQ-012 Total latency D = L1 + L2 + 2 clocks.
REQ-013 cnt_o register loads cnt_i - (D-1) each clock, so cnt_o = cnt_i - D (mod 2^FFT_NLOG2) in steady state.
REQ-014 Arithmetic SHALL be two's complement at DATA_WIDTH with wrap-around: no growth, no scaling, no saturation.
REQ-015 Counters wrap modulo 2^FFT_NLOG2; consecutive blocks stream back-to-back with no bubble.
REQ-016 Output order per stage is block order for the next stage; after the final stage (STAGE=STAGES-1) the order is bit-reversed frequency.
REQ-017 Delay lines may be RAM or shift registers; their contents are not required to reset.

Reset
REQ-018 rst_n=0 SHALL immediately clear z_re_o, z_im_o, cnt_o and all pipeline registers to 0.
REQ-019 Reset mid-block SHALL abandon the block. After release, z is valid from the first full block whose cnt_i started at 0, plus D clocks.

Verification
REQ-020 FFT_N=4, STAGES=1, STAGE=0, DATA_WIDTH=16; cnt_i 0..3 repeating.
- x = 1,0,0,0 -> z = 1,1,1,1 (im 0).
- First output when cnt_i = 5 mod 4; cnt_o = 0,1,2,3.
REQ-021 Same config, x = 1,1,1,1 -> z = 4,0,0,0.
REQ-022 Same config, x = 0,1,0,0 -> z = (1,0),(-1,0),(0,-1),(0,1), i.e. X0,X2,X1,X3.
REQ-023 FFT_N=16, STAGES=2, stages 0 and 1 chained with unit twiddles between them; x = 1 then 15 zeros -> all 16 outputs = 1.
REQ-024 Overflow: DATA_WIDTH=8, x = 127 constant, FFT_N=4 -> X0 = 508 wrapped to 8 bits = -4.
REQ-025 rst_n pulsed low mid-block -> z and cnt_o read 0 during reset; the next full block after release is correct.
